idu_queue: RTL and testbench

Decoupled front half of the decode stage: a parametrised DEPTH-entry instruction buffer between the IFU and the decode/execute path, with a register scoreboard that holds back any instruction whose source or destination register has an outstanding write. Adds branch-redirect flush and multi-instruction buffering to the single-register decode handshake. Sits after IFU (valid_pre/ready_pre side) and feeds decode plus the register read (valid_post/ready_post side).

---
 rtl/idu_queue_pkg.sv | 41 ++++
 rtl/idu_queue_scoreboard.sv | 59 +++++
 rtl/idu_queue.sv | 97 +++++++++
 tb/tb_idu_queue.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idu_queue_pkg.sv
// Shared decode constants for the instruction queue: opcodes, field ranges, bus widths
// and the per-opcode register-usage decode.
package idu_queue_pkg;

    localparam int REG_ADDR_BUS  = 5;
    localparam int INST_ADDR_BUS = 32;
    localparam int INST_DATA_BUS = 32;

    localparam int RS1_HI = 19;
    localparam int RS1_LO = 15;
    localparam int RS2_HI = 24;
    localparam int RS2_LO = 20;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 7;
    localparam int OP_HI  = 6;
    localparam int OP_LO  = 0;

    typedef logic [6:0] opcode_t;

    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic use_rs1;
        logic use_rs2;
        logic wr_rd;
    } reg_use_t;

    function automatic reg_use_t decode_use(input opcode_t op);
        reg_use_t u;
        u.use_rs1 = !(op == OPC_LUI || op == OPC_AUIPC || op == OPC_JAL);
        u.use_rs2 = (op == OPC_BRANCH || op == OPC_STORE || op == OPC_OP);
        u.wr_rd   = !(op == OPC_BRANCH || op == OPC_STORE);
        return u;
    endfunction

endpackage

// File: rtl/idu_queue_scoreboard.sv
// Register scoreboard: one pending-write bit per register, set on issue, cleared on writeback.
// Optional IDU_WB_BYPASS_EN lets a same-cycle writeback mask its busy bit in the hazard check.
module idu_scoreboard
    import idu_queue_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int DATA_W = INST_DATA_BUS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       head_inst_i,
    input  logic                    pop_i,
    input  logic                    wena_i,
    input  logic [$clog2(NREG)-1:0] waddr_i,
    output logic                    hazard_o,
    output logic [NREG-1:0]         busy_o
);
    localparam int RA_W = $clog2(NREG);

    logic [NREG-1:0] busy_q, busy_d, busy_chk;
    logic [RA_W-1:0] rs1, rs2, rd;
    reg_use_t        use_h;

    assign rs1   = RA_W'(head_inst_i[RS1_HI:RS1_LO]);
    assign rs2   = RA_W'(head_inst_i[RS2_HI:RS2_LO]);
    assign rd    = RA_W'(head_inst_i[RD_HI:RD_LO]);
    assign use_h = decode_use(opcode_t'(head_inst_i[OP_HI:OP_LO]));

    always_comb begin
        busy_d = busy_q;
        if (wena_i && waddr_i != '0)
            busy_d[waddr_i] = 1'b0;
        // Set after clear so an issue and a writeback to the same register leave it busy.
        if (pop_i && use_h.wr_rd && rd != '0)
            busy_d[rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        busy_chk = busy_q;
`ifdef IDU_WB_BYPASS_EN
        if (wena_i && waddr_i != '0)
            busy_chk[waddr_i] = 1'b0;
`endif
        hazard_o = (use_h.use_rs1 && busy_chk[rs1]) ||
                   (use_h.use_rs2 && busy_chk[rs2]) ||
                   (use_h.wr_rd   && busy_chk[rd]);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy_q <= '0;
        else
            busy_q <= busy_d;
    end

    assign busy_o = busy_q;

endmodule

// File: rtl/idu_queue.sv
// DEPTH-entry instruction buffer between IFU and decode, gated by a register scoreboard.
// Build option IDU_WB_BYPASS_EN (in idu_scoreboard) enables same-cycle writeback release.
module idu_queue
    import idu_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = INST_ADDR_BUS,
    parameter int DATA_W = INST_DATA_BUS,
    parameter int NREG   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_pre_i,
    output logic                     ready_pre_o,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        inst_i,
    output logic                     valid_post_o,
    input  logic                     ready_post_i,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [DATA_W-1:0]        inst_o,
    input  logic                     wena_i,
    input  logic [$clog2(NREG)-1:0]  waddr_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [NREG-1:0]          busy_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
    logic [DATA_W-1:0] inst_mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             empty, full, push, pop, hazard;
    logic [DATA_W-1:0] head_inst;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign head_inst = inst_mem_q[rptr_q];

    assign ready_pre_o  = !full;
    assign push         = valid_pre_i && !full && !flush_i;
    assign valid_post_o = !empty && !hazard && !flush_i;
    assign pop          = valid_post_o && ready_post_i;

    assign pc_o    = empty ? '0 : pc_mem_q[rptr_q];
    assign inst_o  = empty ? '0 : head_inst;
    assign count_o = count_q;

    always_comb begin
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            wptr_d  = wptr_q + PTR_W'(push);
            rptr_d  = rptr_q + PTR_W'(pop);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: outputs are masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wptr_q]   <= pc_i;
            inst_mem_q[wptr_q] <= inst_i;
        end
    end

    idu_scoreboard #(
        .NREG   (NREG),
        .DATA_W (DATA_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .head_inst_i (head_inst),
        .pop_i       (pop),
        .wena_i      (wena_i),
        .waddr_i     (waddr_i),
        .hazard_o    (hazard),
        .busy_o      (busy_o)
    );

endmodule

// File: tb/tb_idu_queue.sv
// Scoreboard-based bench for idu_queue: expected {pc, inst} pushed on drive, popped on issue.
module tb_idu_queue;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_pre_i = 1'b0;
    logic        ready_pre_o;
    logic [31:0] pc_i = '0;
    logic [31:0] inst_i = '0;
    logic        valid_post_o;
    logic        ready_post_i = 1'b0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        wena_i = 1'b0;
    logic [4:0]  waddr_i = '0;
    logic        flush_i = 1'b0;
    logic [2:0]  count_o;
    logic [31:0] busy_o;

    ent_t exp_q[$];
    int   n_pass = 0;
    int   n_total = 0;

    idu_queue dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .ready_pre_o  (ready_pre_o),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .wena_i       (wena_i),
        .waddr_i      (waddr_i),
        .flush_i      (flush_i),
        .count_o      (count_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_store(input int i);
        return {7'(i), 5'd0, 5'd0, 3'b010, 5'(i), 7'b0100011};
    endfunction
    function automatic logic [31:0] mk_addi(input int rd, input int rs1);
        return {12'd1, 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction
    function automatic logic [31:0] mk_add(input int rd, input int rs1, input int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction
    function automatic logic [31:0] mk_lui(input int rd);
        return {20'h12345, 5'(rd), 7'b0110111};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst);
        valid_pre_i = 1'b1;
        pc_i        = pc;
        inst_i      = inst;
        exp_q.push_back('{pc: pc, inst: inst});
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_total++;
        if (count_o !== 3'd0 || ready_pre_o !== 1'b1 || valid_post_o !== 1'b0)
            $display("FAIL reset_ctrl got count=%0d rdy=%b vld=%b want 0/1/0", count_o, ready_pre_o, valid_post_o);
        else n_pass++;
        n_total++;
        if (busy_o !== 32'd0 || pc_o !== 32'd0 || inst_o !== 32'd0)
            $display("FAIL reset_data got busy=%h pc=%h inst=%h want 0", busy_o, pc_o, inst_o);
        else n_pass++;
        step();
        rst = 1'b1;
        step();
    endtask

    task automatic test_fill_drain();
        ent_t e;
        ready_post_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid_pre_i = 1'b1;
            pc_i   = 32'h1000 + 32'(4 * i);
            inst_i = mk_store(i + 1);
            @(negedge clk);
            n_total++;
            if (ready_pre_o !== (i < 4))
                $display("FAIL fill_ready[%0d] got %b want %b", i, ready_pre_o, (i < 4));
            else n_pass++;
            if (i < 4) exp_q.push_back('{pc: pc_i, inst: inst_i});
            step();
        end
        valid_pre_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (count_o !== 3'd4 || valid_post_o !== 1'b1 || pc_o !== exp_q[0].pc)
            $display("FAIL fill_full got count=%0d vld=%b pc=%h want 4/1/%h", count_o, valid_post_o, pc_o, exp_q[0].pc);
        else n_pass++;
        step();
        ready_post_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if (valid_post_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst)
                $display("FAIL drain[%0d] got vld=%b pc=%h inst=%h want 1 %h %h", i, valid_post_o, pc_o, inst_o, e.pc, e.inst);
            else n_pass++;
            step();
        end
        n_total++;
        if (count_o !== 3'd0 || valid_post_o !== 1'b0)
            $display("FAIL drain_empty got count=%0d vld=%b want 0/0", count_o, valid_post_o);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        ent_t e;
        ready_post_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 6) drive(32'h2000 + 32'(4 * i), mk_store(i + 9));
            else valid_pre_i = 1'b0;
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                n_total++;
                if (valid_post_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst || count_o !== 3'd1)
                    $display("FAIL b2b[%0d] got vld=%b pc=%h cnt=%0d want 1 %h 1", i, valid_post_o, pc_o, count_o, e.pc);
                else n_pass++;
            end
            step();
        end
        n_total++;
        if (count_o !== 3'd0)
            $display("FAIL b2b_empty got count=%0d want 0", count_o);
        else n_pass++;
    endtask

    task automatic test_raw();
        ent_t e;
        ready_post_i = 1'b1;
        drive(32'h100, mk_addi(5, 0));
        step();
        drive(32'h104, mk_add(6, 5, 1));
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL raw_first got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
        step();
        valid_pre_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++;
            if (busy_o[5] !== 1'b1 || valid_post_o !== 1'b0)
                $display("FAIL raw_held[%0d] got busy5=%b vld=%b want 1/0", i, busy_o[5], valid_post_o);
            else n_pass++;
            step();
        end
        wena_i = 1'b1;
        waddr_i = 5'd5;
        @(negedge clk);
`ifdef IDU_WB_BYPASS_EN
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL raw_bypass got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
`else
        n_total++;
        if (valid_post_o !== 1'b0)
            $display("FAIL raw_wb_cycle got vld=%b want 0", valid_post_o);
        else n_pass++;
`endif
        step();
        wena_i = 1'b0;
        @(negedge clk);
`ifndef IDU_WB_BYPASS_EN
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst)
            $display("FAIL raw_release got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
`endif
        n_total++;
        if (busy_o[5] !== 1'b0)
            $display("FAIL raw_clear got busy5=%b want 0", busy_o[5]);
        else n_pass++;
        step();
        n_total++;
        if (busy_o !== 32'h40 || count_o !== 3'd0)
            $display("FAIL raw_rd6 got busy=%h cnt=%0d want 00000040 0", busy_o, count_o);
        else n_pass++;
        wena_i = 1'b1;
        waddr_i = 5'd6;
        step();
        wena_i = 1'b0;
    endtask

    task automatic test_x0_waw();
        ent_t e;
        ready_post_i = 1'b1;
        drive(32'h200, mk_addi(0, 0));
        step();
        drive(32'h204, mk_addi(7, 0));
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL x0_issue got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
        step();
        n_total++;
        if (busy_o !== 32'd0)
            $display("FAIL x0_busy got busy=%h want 0", busy_o);
        else n_pass++;
        drive(32'h208, mk_lui(7));
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL waw_first got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
        step();
        valid_pre_i = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy_o[7] !== 1'b1 || valid_post_o !== 1'b0)
            $display("FAIL waw_held got busy7=%b vld=%b want 1/0", busy_o[7], valid_post_o);
        else n_pass++;
        step();
        wena_i = 1'b1;
        waddr_i = 5'd7;
        @(negedge clk);
`ifdef IDU_WB_BYPASS_EN
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL waw_bypass got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
`else
        n_total++;
        if (valid_post_o !== 1'b0)
            $display("FAIL waw_wb_cycle got vld=%b want 0", valid_post_o);
        else n_pass++;
`endif
        step();
        wena_i = 1'b0;
        @(negedge clk);
`ifndef IDU_WB_BYPASS_EN
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst)
            $display("FAIL waw_release got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
`endif
        step();
        n_total++;
        if (busy_o !== 32'h80)
            $display("FAIL waw_lui_busy got busy=%h want 00000080", busy_o);
        else n_pass++;
        wena_i = 1'b1;
        waddr_i = 5'd7;
        step();
        wena_i = 1'b0;
    endtask

    task automatic test_flush();
        ent_t e;
        logic [31:0] busy_before;
        ready_post_i = 1'b1;
        drive(32'h300, mk_addi(3, 0));
        step();
        valid_pre_i = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        step();
        ready_post_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h310 + 32'(4 * i), mk_store(20 + i));
            step();
        end
        busy_before = busy_o;
        n_total++;
        if (count_o !== 3'd3 || busy_before !== 32'h8)
            $display("FAIL flush_pre got cnt=%0d busy=%h want 3 00000008", count_o, busy_before);
        else n_pass++;
        valid_pre_i = 1'b1;
        pc_i   = 32'h3F0;
        inst_i = mk_store(30);
        flush_i = 1'b1;
        exp_q.delete();
        @(negedge clk);
        n_total++;
        if (valid_post_o !== 1'b0)
            $display("FAIL flush_gate got vld=%b want 0", valid_post_o);
        else n_pass++;
        step();
        flush_i = 1'b0;
        valid_pre_i = 1'b0;
        n_total++;
        if (count_o !== 3'd0 || valid_post_o !== 1'b0 || busy_o !== busy_before)
            $display("FAIL flush_after got cnt=%0d vld=%b busy=%h want 0 0 %h", count_o, valid_post_o, busy_o, busy_before);
        else n_pass++;
        drive(32'h400, mk_store(31));
        ready_post_i = 1'b1;
        step();
        valid_pre_i = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc || inst_o !== e.inst)
            $display("FAIL flush_refill got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
        wena_i = 1'b1;
        waddr_i = 5'd3;
        step();
        wena_i = 1'b0;
    endtask

    task automatic test_collision();
        ent_t e;
        ready_post_i = 1'b1;
        drive(32'h500, mk_addi(9, 0));
        step();
        valid_pre_i = 1'b0;
        wena_i  = 1'b1;
        waddr_i = 5'd9;
        @(negedge clk);
        e = exp_q.pop_front();
        n_total++;
        if (valid_post_o !== 1'b1 || pc_o !== e.pc)
            $display("FAIL coll_issue got vld=%b pc=%h want 1 %h", valid_post_o, pc_o, e.pc);
        else n_pass++;
        step();
        wena_i = 1'b0;
        n_total++;
        if (busy_o !== 32'h200)
            $display("FAIL coll_set_wins got busy=%h want 00000200", busy_o);
        else n_pass++;
        wena_i = 1'b1;
        step();
        wena_i = 1'b0;
        n_total++;
        if (busy_o !== 32'd0)
            $display("FAIL coll_clear got busy=%h want 0", busy_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        ent_t e;
        ready_post_i = 1'b1;
        drive(32'h600, mk_addi(10, 0));
        step();
        valid_pre_i = 1'b0;
        @(negedge clk);
        e = exp_q.pop_front();
        step();
        ready_post_i = 1'b0;
        drive(32'h610, mk_store(40));
        step();
        drive(32'h614, mk_store(41));
        step();
        valid_pre_i = 1'b0;
        n_total++;
        if (count_o !== 3'd2 || busy_o !== 32'h400)
            $display("FAIL arst_pre got cnt=%0d busy=%h want 2 00000400", count_o, busy_o);
        else n_pass++;
        #2;
        rst = 1'b0;
        #1;
        n_total++;
        if (count_o !== 3'd0 || ready_pre_o !== 1'b1 || valid_post_o !== 1'b0 ||
            busy_o !== 32'd0 || pc_o !== 32'd0 || inst_o !== 32'd0)
            $display("FAIL arst_now got cnt=%0d rdy=%b vld=%b busy=%h pc=%h want 0 1 0 0 0",
                     count_o, ready_pre_o, valid_post_o, busy_o, pc_o);
        else n_pass++;
        exp_q.delete();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_back_to_back();
        test_raw();
        test_x0_waw();
        test_flush();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
